ltc_reader: RTL and testbench
=============================

Name: ltc_reader

Overview:
- Receive-side counterpart of the LTC generator.
- Recovers SMPTE linear timecode from a single biphase-mark line.
- Frames the 80-bit word on the sync word and presents hours/minutes/seconds/frames as BCD, plus the drop-frame flag and the 32 user bits.
- Sits between a pad input (ltc line, asynchronous to clk) and display/compare logic.
- Covers 24/25/30 fps forward playback only.

Parameters:
- CNT_W, 16, width of the edge-interval counter.
- MIN_INT, 1000, intervals below this many clk cycles are glitches (error).
- THRESH, 3385, intervals <= THRESH are half-bit ("short"); above are full-bit ("long").
- MAX_INT, 6500, intervals above this many cycles mean timeout / line lost.
- The three timing defaults assume a 10 MHz clk.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- timecode_in  input  1  raw LTC line, asynchronous
- frame_valid  output  1  one-cycle pulse; all field outputs updated this cycle
- locked  output  1  two or more consecutive frames exactly 80 bits apart
- error  output  1  one-cycle pulse on glitch, timeout, biphase violation or overrun
- hours_bcd  output  6  {tens[1:0], units[3:0]}
- minutes_bcd  output  7  {tens[2:0], units[3:0]}
- seconds_bcd  output  7  {tens[2:0], units[3:0]}
- frames_bcd  output  6  {tens[1:0], units[3:0]}
- drop_frame  output  1  LTC bit 10
- user_bits  output  32  user groups 1..8 concatenated, group1 in [3:0]

Behaviour:
- Reset state:
  - All outputs 0.
  - Synchronizer flops, interval counter, half_pending, have_ref, sync_seen, bit_cnt and the 80-bit shift register sr all 0.
- Input path and latency:
  - Two-flop synchronizer, then a third flop for edge detect.
  - Let k be the first clk edge that samples a changed level: sync1 @k, sync2 @k+1.
  - Decoded bit strobe registered @k+2.
  - sr/bit_cnt update, plus frame_valid and output fields, @k+3.
  - Total latency: 4 clocks, fixed.
- Interval counter:
  - Cleared on each detected edge, otherwise increments.
  - Saturates at MAX_INT+1.
  - Interval = counter value at the edge + 1.
- Reference edge:
  - The first edge after reset or after any error only sets have_ref and restarts the counter.
  - No classification occurs on that edge.
- Classification at each subsequent edge:
  - interval < MIN_INT: error, clear have_ref/half_pending/sync_seen/locked.
  - interval <= THRESH (short): if half_pending=0, set half_pending; else emit bit 1 and clear half_pending.
  - interval <= MAX_INT (long): if half_pending=1, biphase error (same recovery as a glitch); else emit bit 0.
- Timeout:
  - Counter reaching MAX_INT+1 while have_ref=1 raises error once.
  - Recovery is the same as a glitch.
- Bit shift:
  - New bit enters sr[79]; sr shifts right, so after 80 bits sr[0] holds LTC bit 0.
  - bit_cnt increments per bit and saturates at 127.
- Sync match: next sr[79:64] == SYNC_WORD (16'hBFFC, i.e. LTC bits 64..79 = 0011111111111101).
- Accept condition:
  - Sync match and bit_cnt (including this bit) >= 80.
  - On accept: pulse frame_valid, load all fields from sr bits 0..63, clear bit_cnt, set sync_seen.
  - locked is set if sync_seen was already 1 and the count was exactly 80.
- Overrun: locked=1 and the 81st bit arrives without an accept -> error, locked cleared, sync_seen cleared.
- Sync match with bit_cnt < 80 is ignored (no pulse).
- Field bit positions (LTC numbering):
  - frame units 0-3, frame tens 8-9, drop frame 10;
  - sec units 16-19, sec tens 24-26;
  - min units 32-35, min tens 40-42;
  - hr units 48-51, hr tens 56-57;
  - user groups at 4-7, 12-15, 20-23, 28-31, 36-39, 44-47, 52-55, 60-63.
- Field outputs hold their values between accepts, including across errors; only reset clears them.
- BCD values are passed through unchecked.
- Reversed-direction sync is not detected.
- Reset mid-frame: the partial word is discarded; the next full frame is decoded normally.

Decomposition:
- Shared package ltc_pkg holds:
  - SYNC_WORD;
  - LTC field bit-position constants;
  - frame length 80;
  - default timing constants for 10 MHz.
- Sub-module ltc_bmc_decoder holds the synchronizer, edge detect, interval counter, classification and have_ref/half_pending.
  - Outputs: bit_strobe, bit_val, bmc_error.
- ltc_reader itself holds the sr, bit_cnt, sync/accept/lock logic and output registers.

Test Plan:
All scenarios override MIN_INT=4, THRESH=15, MAX_INT=26 and drive half-bit 10 / full-bit 20 cycles.
1. Reset, one reference edge, then frame 01:23:45:12 -> one frame_valid exactly 4 clk after the final edge of bit 79; hours_bcd=6'h01, minutes_bcd=7'h23, seconds_bcd=7'h45, frames_bcd=6'h12; locked=0.
2. Back-to-back frames 00:00:59:29 then 00:01:00:00 -> two pulses 80 bit-periods apart; second shows 7'h01 minutes, 0 seconds/frames; locked=1 from the second pulse.
3. Frame with drop_frame=1 and user_bits=32'hDEADBEEF -> drop_frame=1, user_bits=32'hDEADBEEF.
4. While locked, insert a 2-cycle glitch mid-frame -> error pulse, locked=0, no frame_valid for that word; the next full frame decodes with locked=0; the following one sets locked=1.
5. While locked, hold the line static for 40 cycles -> single error pulse once the counter reaches 27, locked=0. Separately, short-then-long sequence -> error.
6. Assert reset at bit 40 of a frame -> all outputs 0 the next cycle; no spurious frame_valid; the subsequent complete frame decodes correctly.

Source files
------------

// File: rtl/ltc_pkg.sv
// rtl/ltc_pkg.sv - shared LTC constants: sync word, field positions, frame length, 10 MHz timing
package ltc_pkg;

  localparam int          FRAME_LEN   = 80;
  localparam logic [15:0] SYNC_WORD   = 16'hBFFC;

  localparam int DEF_MIN_INT = 1000;
  localparam int DEF_THRESH  = 3385;
  localparam int DEF_MAX_INT = 6500;

  localparam int POS_FRM_U  = 0;
  localparam int POS_FRM_T  = 8;
  localparam int POS_DROP   = 10;
  localparam int POS_SEC_U  = 16;
  localparam int POS_SEC_T  = 24;
  localparam int POS_MIN_U  = 32;
  localparam int POS_MIN_T  = 40;
  localparam int POS_HR_U   = 48;
  localparam int POS_HR_T   = 56;
  localparam int USER_BASE   = 4;
  localparam int USER_STRIDE = 8;

  // User group g (0-based) sits in the upper nibble of each 8-bit LTC slot.
  function automatic logic [31:0] user_groups(input logic [FRAME_LEN-1:0] w);
    logic [31:0] u;
    u = '0;
    for (int g = 0; g < 8; g++) u[4*g +: 4] = w[USER_BASE + USER_STRIDE*g +: 4];
    return u;
  endfunction

endpackage

// File: rtl/ltc_bmc_decoder.sv
// rtl/ltc_bmc_decoder.sv - biphase-mark line decoder: sync, edge timing, half/full-bit classification
module ltc_bmc_decoder
  import ltc_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MIN_INT = DEF_MIN_INT,
  parameter int THRESH  = DEF_THRESH,
  parameter int MAX_INT = DEF_MAX_INT
) (
  input  logic clk,
  input  logic reset,
  input  logic ltc_line,
  output logic bit_strobe,
  output logic bit_val,
  output logic bmc_error
);

  localparam logic [CNT_W:0]   MIN_L    = (CNT_W+1)'(MIN_INT);
  localparam logic [CNT_W:0]   THR_L    = (CNT_W+1)'(THRESH);
  localparam logic [CNT_W:0]   MAX_L    = (CNT_W+1)'(MAX_INT);
  localparam logic [CNT_W:0]   INT_ONE  = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_INT);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_INT + 1);

  logic             sync1, sync2, sync3;
  logic [CNT_W-1:0] cnt;
  logic             have_ref, half_pending;
  logic             edge_det;
  logic [CNT_W:0]   interval;

  assign edge_det = sync2 ^ sync3;
  assign interval = {1'b0, cnt} + INT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync3        <= 1'b0;
      cnt          <= '0;
      have_ref     <= 1'b0;
      half_pending <= 1'b0;
      bit_strobe   <= 1'b0;
      bit_val      <= 1'b0;
      bmc_error    <= 1'b0;
    end else begin
      sync1      <= ltc_line;
      sync2      <= sync1;
      sync3      <= sync2;
      bit_strobe <= 1'b0;
      bmc_error  <= 1'b0;
      if (edge_det) begin
        cnt <= '0;
        if (!have_ref) begin
          have_ref     <= 1'b1;
          half_pending <= 1'b0;
        end else if (interval < MIN_L || interval > MAX_L) begin
          bmc_error    <= 1'b1;
          have_ref     <= 1'b0;
          half_pending <= 1'b0;
        end else if (interval <= THR_L) begin
          if (half_pending) begin
            bit_strobe   <= 1'b1;
            bit_val      <= 1'b1;
            half_pending <= 1'b0;
          end else begin
            half_pending <= 1'b1;
          end
        end else if (half_pending) begin
          // A full-bit interval in the middle of a "1" cell is a biphase violation.
          bmc_error    <= 1'b1;
          have_ref     <= 1'b0;
          half_pending <= 1'b0;
        end else begin
          bit_strobe <= 1'b1;
          bit_val    <= 1'b0;
        end
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + CNT_ONE;
        if (cnt == CNT_LAST && have_ref) begin
          bmc_error    <= 1'b1;
          have_ref     <= 1'b0;
          half_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ltc_reader.sv
// rtl/ltc_reader.sv - SMPTE LTC reader: frames the 80-bit word on sync and presents BCD time fields
module ltc_reader
  import ltc_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MIN_INT = DEF_MIN_INT,
  parameter int THRESH  = DEF_THRESH,
  parameter int MAX_INT = DEF_MAX_INT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        timecode_in,
  output logic        frame_valid,
  output logic        locked,
  output logic        error,
  output logic [5:0]  hours_bcd,
  output logic [6:0]  minutes_bcd,
  output logic [6:0]  seconds_bcd,
  output logic [5:0]  frames_bcd,
  output logic        drop_frame,
  output logic [31:0] user_bits
);

  localparam logic [6:0] LEN     = 7'(FRAME_LEN);
  localparam logic [6:0] CNT_SAT = 7'd127;

  logic                 bit_strobe, bit_val, bmc_error;
  // The oldest word bit is only needed combinationally, so it is never stored.
  logic [FRAME_LEN-1:1] sr;
  logic [FRAME_LEN-1:0] sr_next;
  logic [6:0]           bit_cnt, cnt_next;
  logic                 sync_seen, accept, overrun;

  ltc_bmc_decoder #(
    .CNT_W  (CNT_W),
    .MIN_INT(MIN_INT),
    .THRESH (THRESH),
    .MAX_INT(MAX_INT)
  ) u_bmc (
    .clk       (clk),
    .reset     (reset),
    .ltc_line  (timecode_in),
    .bit_strobe(bit_strobe),
    .bit_val   (bit_val),
    .bmc_error (bmc_error)
  );

  assign sr_next  = {bit_val, sr};
  assign cnt_next = (bit_cnt == CNT_SAT) ? bit_cnt : bit_cnt + 7'd1;
  assign accept   = bit_strobe && (sr_next[FRAME_LEN-1 -: 16] == SYNC_WORD) && (cnt_next >= LEN);
  assign overrun  = bit_strobe && !accept && locked && (cnt_next > LEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr          <= '0;
      bit_cnt     <= '0;
      sync_seen   <= 1'b0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      error       <= 1'b0;
      hours_bcd   <= '0;
      minutes_bcd <= '0;
      seconds_bcd <= '0;
      frames_bcd  <= '0;
      drop_frame  <= 1'b0;
      user_bits   <= '0;
    end else begin
      frame_valid <= 1'b0;
      error       <= bmc_error | overrun;
      if (bmc_error) begin
        sync_seen <= 1'b0;
        locked    <= 1'b0;
      end else if (bit_strobe) begin
        sr <= sr_next[FRAME_LEN-1:1];
        if (accept) begin
          frame_valid <= 1'b1;
          bit_cnt     <= '0;
          sync_seen   <= 1'b1;
          locked      <= sync_seen && (cnt_next == LEN);
          hours_bcd   <= {sr_next[POS_HR_T +: 2], sr_next[POS_HR_U +: 4]};
          minutes_bcd <= {sr_next[POS_MIN_T +: 3], sr_next[POS_MIN_U +: 4]};
          seconds_bcd <= {sr_next[POS_SEC_T +: 3], sr_next[POS_SEC_U +: 4]};
          frames_bcd  <= {sr_next[POS_FRM_T +: 2], sr_next[POS_FRM_U +: 4]};
          drop_frame  <= sr_next[POS_DROP];
          user_bits   <= user_groups(sr_next);
        end else begin
          bit_cnt <= cnt_next;
          if (overrun) begin
            locked    <= 1'b0;
            sync_seen <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ltc_reader.sv
// tb/tb_ltc_reader.sv - self-checking bench for ltc_reader with a timecode-level reference model
module tb_ltc_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tc_line = 1'b0;
  logic        frame_valid, locked, error, drop_frame;
  logic [5:0]  hours_bcd, frames_bcd;
  logic [6:0]  minutes_bcd, seconds_bcd;
  logic [31:0] user_bits;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_edge = 0;

  typedef struct {int h; int m; int s; int f; logic df; logic [31:0] ub;} tc_t;
  typedef struct {
    logic [5:0] h; logic [6:0] m; logic [6:0] s; logic [5:0] f;
    logic df; logic [31:0] ub; logic lk; int cyc;
  } cap_t;

  cap_t fv_q[$];
  cap_t mon_cap;

  ltc_reader #(.CNT_W(16), .MIN_INT(4), .THRESH(15), .MAX_INT(26)) dut (
    .clk(clk), .reset(reset), .timecode_in(tc_line),
    .frame_valid(frame_valid), .locked(locked), .error(error),
    .hours_bcd(hours_bcd), .minutes_bcd(minutes_bcd), .seconds_bcd(seconds_bcd),
    .frames_bcd(frames_bcd), .drop_frame(drop_frame), .user_bits(user_bits)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      mon_cap.h = hours_bcd;   mon_cap.m = minutes_bcd; mon_cap.s = seconds_bcd;
      mon_cap.f = frames_bcd;  mon_cap.df = drop_frame; mon_cap.ub = user_bits;
      mon_cap.lk = locked;     mon_cap.cyc = cyc;
      fv_q.push_back(mon_cap);
    end
    if (error) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] bcd6(input int v);
    return {2'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] bcd7(input int v);
    return {3'(v / 10), 4'(v % 10)};
  endfunction

  // Reference encoder: timecode -> 80 LTC bits in transmission order.
  function automatic logic [79:0] ltc_word(input tc_t t);
    logic [79:0] w;
    w = '0;
    w[3:0]   = 4'(t.f % 10);  w[9:8]   = 2'(t.f / 10); w[10] = t.df;
    w[19:16] = 4'(t.s % 10);  w[26:24] = 3'(t.s / 10);
    w[35:32] = 4'(t.m % 10);  w[42:40] = 3'(t.m / 10);
    w[51:48] = 4'(t.h % 10);  w[57:56] = 2'(t.h / 10);
    for (int g = 0; g < 8; g++) w[4 + 8*g +: 4] = t.ub[4*g +: 4];
    for (int b = 64; b < 80; b++) w[b] = (b >= 66 && b <= 77) || b == 79;
    return w;
  endfunction

  function automatic tc_t rand_tc();
    tc_t t;
    t.h = int'($urandom_range(23, 0)); t.m = int'($urandom_range(59, 0));
    t.s = int'($urandom_range(59, 0)); t.f = int'($urandom_range(29, 0));
    t.df = 1'b0; t.ub = $urandom();
    return t;
  endfunction

  task automatic toggle();
    tc_line = ~tc_line;
    last_edge = cyc;
  endtask

  task automatic send_bit(input logic b);
    if (b) begin
      repeat (10) @(negedge clk); toggle();
      repeat (10) @(negedge clk); toggle();
    end else begin
      repeat (20) @(negedge clk); toggle();
    end
  endtask

  // glitch_at must name a 0 bit; that cell gets two extra edges 2 cycles apart.
  task automatic send_frame(input logic [79:0] w, input int glitch_at);
    for (int k = 0; k < 80; k++) begin
      if (k == glitch_at) begin
        repeat (9) @(negedge clk); toggle();
        repeat (2) @(negedge clk); toggle();
        repeat (9) @(negedge clk); toggle();
      end else begin
        send_bit(w[k]);
      end
    end
  endtask

  task automatic check_frame(input string tag, input tc_t t, input logic exp_lk, output int fv_cyc);
    cap_t c;
    fv_cyc = -1;
    chk({tag, "_present"}, 64'(fv_q.size() > 0), 64'(1));
    if (fv_q.size() == 0) return;
    c = fv_q.pop_front();
    fv_cyc = c.cyc;
    chk({tag, "_hours"},   c.h,  bcd6(t.h));
    chk({tag, "_minutes"}, c.m,  bcd7(t.m));
    chk({tag, "_seconds"}, c.s,  bcd7(t.s));
    chk({tag, "_frames"},  c.f,  bcd6(t.f));
    chk({tag, "_drop"},    c.df, t.df);
    chk({tag, "_user"},    c.ub, t.ub);
    chk({tag, "_locked"},  c.lk, exp_lk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_fv"}, frame_valid, 0);  chk({tag, "_locked"}, locked, 0);
    chk({tag, "_error"}, error, 0);     chk({tag, "_hours"}, hours_bcd, 0);
    chk({tag, "_minutes"}, minutes_bcd, 0); chk({tag, "_seconds"}, seconds_bcd, 0);
    chk({tag, "_frames"}, frames_bcd, 0);   chk({tag, "_drop"}, drop_frame, 0);
    chk({tag, "_user"}, user_bits, 0);
  endtask

  initial begin
    tc_t a, b, c, d, e, f, g, h, i;
    logic [79:0] w;
    int e0, fa, fb, fc, fx, le_a, gl, rst_at;

    repeat (4) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Scenario 1: single frame after a reference edge, then line goes idle.
    a = '{h: 1, m: 23, s: 45, f: 12, df: 1'b0, ub: $urandom()};
    repeat (3) @(negedge clk);
    toggle();
    send_frame(ltc_word(a), -1);
    le_a = last_edge;
    repeat (6) @(negedge clk);
    chk("s1_count", 64'(fv_q.size()), 64'(1));
    check_frame("s1", a, 1'b0, fa);
    chk("s1_latency", 64'(fa - le_a), 64'(4));
    e0 = err_cnt;
    repeat (40) @(negedge clk);
    chk("s1_idle_errors", 64'(err_cnt - e0), 64'(1));
    chk("s1_idle_fv", 64'(fv_q.size()), 64'(0));

    // Scenarios 2-4: continuous stream B C D E(glitched) F G.
    b = '{h: 0, m: 0, s: 59, f: 29, df: 1'b0, ub: $urandom()};
    c = '{h: 0, m: 1, s: 0, f: 0, df: 1'b0, ub: $urandom()};
    d = rand_tc(); d.df = 1'b1; d.ub = 32'hDEADBEEF;
    e = rand_tc(); f = rand_tc(); g = rand_tc();
    w = ltc_word(e);
    gl = 40;
    while (w[gl]) gl++;
    e0 = err_cnt;
    toggle();
    send_frame(ltc_word(b), -1);
    send_frame(ltc_word(c), -1);
    send_frame(ltc_word(d), -1);
    chk("s3_locked_before_glitch", locked, 1'b1);
    send_frame(w, gl);
    chk("s4_locked_after_glitch", locked, 1'b0);
    chk("s4_glitch_errors", 64'(err_cnt - e0), 64'(1));
    send_frame(ltc_word(f), -1);
    send_frame(ltc_word(g), -1);
    repeat (6) @(negedge clk);
    chk("s2_count", 64'(fv_q.size()), 64'(5));
    check_frame("s2_b", b, 1'b0, fb);
    check_frame("s2_c", c, 1'b1, fc);
    chk("s2_spacing", 64'(fc - fb), 64'(1600));
    check_frame("s3_d", d, 1'b1, fx);
    check_frame("s4_f", f, 1'b0, fx);
    check_frame("s4_g", g, 1'b1, fx);

    // Scenario 5: static line while locked, then short-then-long violation.
    e0 = err_cnt;
    repeat (40) @(negedge clk);
    chk("s5_timeout_errors", 64'(err_cnt - e0), 64'(1));
    chk("s5_timeout_locked", locked, 1'b0);
    chk("s5_hold_hours", hours_bcd, bcd6(g.h));
    e0 = err_cnt;
    toggle();
    repeat (10) @(negedge clk); toggle();
    repeat (20) @(negedge clk); toggle();
    repeat (40) @(negedge clk);
    chk("s5_biphase_errors", 64'(err_cnt - e0), 64'(1));
    chk("s5_biphase_fv", 64'(fv_q.size()), 64'(0));

    // Scenario 6: reset mid-frame at a low-level 0 cell at or after bit 40.
    h = rand_tc(); i = rand_tc();
    w = ltc_word(h);
    rst_at = -1;
    e0 = err_cnt;
    toggle();
    for (int k = 0; k < 80; k++) begin
      if (rst_at < 0 && k >= 40 && !w[k] && !tc_line) begin
        rst_at = k;
        reset = 1'b1;
        @(negedge clk);
        check_zero("s6_reset");
        reset = 1'b0;
      end
      send_bit(w[k]);
    end
    chk("s6_reset_taken", 64'(rst_at >= 40), 64'(1));
    send_frame(ltc_word(i), -1);
    repeat (6) @(negedge clk);
    chk("s6_count", 64'(fv_q.size()), 64'(1));
    check_frame("s6_i", i, 1'b0, fx);
    repeat (40) @(negedge clk);
    chk("s6_errors", 64'(err_cnt - e0), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
